// File: rtl/multi_delay_ctrl_pkg.sv
// Shared constants and types for the multi-channel delay controller.
// Holds the register map, CTRL bit positions, channel FSM states and a clamp helper.
package multi_delay_pkg;

  localparam logic [4:0] ADDR_CTRL     = 5'd16;
  localparam logic [4:0] ADDR_STATUS   = 5'd17;
  localparam int         CTRL_LOCK_BIT = 0;
  localparam int         MAX_CH        = 16;
  localparam int         STATUS_MAX_LSB = 16;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_HOLD = 1'b1
  } ch_state_e;

  // Saturate v into [lo, hi]; all operands treated as unsigned 32-bit.
  function automatic logic [31:0] clamp_u32(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

endpackage

// File: rtl/multi_delay_ctrl_if.sv
// Avalon-MM slave register bus of the delay controller.
// read/write are single-cycle strobes with no waitrequest: every cycle a strobe is high
// is one accepted transfer, and readdata is valid exactly one cycle after read.
interface multi_delay_ctrl_if;
  logic [4:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output write,
    output writedata,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  read,
    output readdata
  );
endinterface

// File: rtl/multi_delay_ctrl_channel.sv
// One delay channel: stored value with write clamp, saturating step and cooldown FSM.
// A register write always wins over a step and drops any cooldown in progress.
module delay_channel
  import multi_delay_pkg::*;
#(
  parameter int DW          = 8,
  parameter int MIN_DELAY   = 8,
  parameter int MAX_DELAY   = 15,
  parameter int RESET_DELAY = 8,
  parameter int COOLDOWN    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          faster_i,
  input  logic          slower_i,
  input  logic          lock_i,
  input  logic          wr_en_i,
  input  logic [31:0]   wr_data_i,
  output logic [DW-1:0] delay_o,
  output logic          at_min_o,
  output logic          at_max_o,
  output ch_state_e     state_o
);

  localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [31:0]   MIN32 = 32'(MIN_DELAY);
  localparam logic [31:0]   MAX32 = 32'(MAX_DELAY);
  localparam logic [DW-1:0] MIN_V = DW'(MIN_DELAY);
  localparam logic [DW-1:0] MAX_V = DW'(MAX_DELAY);
  localparam logic [DW-1:0] RST_V = DW'(clamp_u32(32'(RESET_DELAY), MIN32, MAX32));
  localparam logic [CW-1:0] CD_V  = CW'(COOLDOWN);

  logic [DW-1:0] value_q, value_d;
  logic          at_min_q, at_max_q;
  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_up, step_dn;

  // A step request against a saturated value is not a step, so it never starts a cooldown.
  assign step_up = slower_i & ~faster_i & ~lock_i & (value_q != MAX_V);
  assign step_dn = faster_i & ~slower_i & ~lock_i & (value_q != MIN_V);

  always_comb begin
    value_d = value_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr_en_i) begin
      value_d = DW'(clamp_u32(wr_data_i, MIN32, MAX32));
      state_d = CH_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (step_up || step_dn) begin
            value_d = step_up ? value_q + 1'b1 : value_q - 1'b1;
            if (COOLDOWN > 0) begin
              state_d = CH_HOLD;
              cnt_d   = CD_V;
            end
          end
        end
        CH_HOLD: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = CH_IDLE;
        end
        default: begin
          state_d = CH_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= RST_V;
      at_min_q <= (RST_V == MIN_V);
      at_max_q <= (RST_V == MAX_V);
      state_q  <= CH_IDLE;
      cnt_q    <= '0;
    end else begin
      value_q  <= value_d;
      at_min_q <= (value_d == MIN_V);
      at_max_q <= (value_d == MAX_V);
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  assign delay_o  = value_q;
  assign at_min_o = at_min_q;
  assign at_max_o = at_max_q;
  assign state_o  = state_q;

endmodule

// File: rtl/multi_delay_ctrl.sv
// Multi-channel delay controller: NUM_CH stepped delay registers behind an Avalon-MM slave.
// Addresses 0..NUM_CH-1 hold channel delays, 16 is CTRL (lock), 17 is read-only STATUS.
module multi_delay_ctrl
  import multi_delay_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DW          = 8,
  parameter int MIN_DELAY   = 8,
  parameter int MAX_DELAY   = 15,
  parameter int RESET_DELAY = 8,
  parameter int COOLDOWN    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    faster,
  input  logic [NUM_CH-1:0]    slower,
  output logic [NUM_CH*DW-1:0] delay,
  output logic [NUM_CH-1:0]    at_min,
  output logic [NUM_CH-1:0]    at_max,
  output logic [NUM_CH-1:0]    dbg_hold_o,
  multi_delay_ctrl_if.slave    bus
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("multi_delay_ctrl: NUM_CH must be 1..16");
  end
  if (MIN_DELAY > MAX_DELAY || MAX_DELAY >= (2 ** DW)) begin : g_bad_range
    $error("multi_delay_ctrl: need MIN_DELAY <= MAX_DELAY < 2**DW");
  end

  logic              lock_q, lock_d;
  logic [31:0]       readdata_q, readdata_d;
  logic [31:0]       rd_data;
  logic [DW-1:0]     ch_delay [NUM_CH];
  logic [NUM_CH-1:0] ch_wr_en;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ch_state_e ch_state;

    assign ch_wr_en[k] = bus.write && (bus.address == 5'(k));

    delay_channel #(
      .DW          (DW),
      .MIN_DELAY   (MIN_DELAY),
      .MAX_DELAY   (MAX_DELAY),
      .RESET_DELAY (RESET_DELAY),
      .COOLDOWN    (COOLDOWN)
    ) u_ch (
      .clk       (clk),
      .rst_n     (reset_n),
      .faster_i  (faster[k]),
      .slower_i  (slower[k]),
      .lock_i    (lock_q),
      .wr_en_i   (ch_wr_en[k]),
      .wr_data_i (bus.writedata),
      .delay_o   (ch_delay[k]),
      .at_min_o  (at_min[k]),
      .at_max_o  (at_max[k]),
      .state_o   (ch_state)
    );

    assign delay[k*DW +: DW] = ch_delay[k];
    assign dbg_hold_o[k]     = (ch_state == CH_HOLD);
  end

  always_comb begin
    lock_d = lock_q;
    if (bus.write && bus.address == ADDR_CTRL) lock_d = bus.writedata[CTRL_LOCK_BIT];
  end

  // The mux sees pre-write register contents, so a same-cycle read and write returns the old value.
  always_comb begin
    rd_data = '0;
    if (bus.address == ADDR_CTRL) begin
      rd_data[CTRL_LOCK_BIT] = lock_q;
    end else if (bus.address == ADDR_STATUS) begin
      rd_data[NUM_CH-1:0]                  = at_min;
      rd_data[STATUS_MAX_LSB +: NUM_CH]    = at_max;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.address == 5'(k)) rd_data = 32'(ch_delay[k]);
      end
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (bus.read) readdata_d = rd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      lock_q     <= lock_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

endmodule
